// File: rtl/pixel_framebuf.sv
// pixel_framebuf: 8x8 one-bit bitmap filled by a rasterizer's pixel strobes.
// When the rasterizer goes idle, the bitmap is drained row by row through a
// valid/ready port. The bitmap is then cleared for the next frame.
// Parameter DRAIN_BOTTOM_UP selects the drain order (0: rows 0..7, 1: rows 7..0).
// Optional macro DUP_DETECT_EN enables repeated-pixel detection. With it, a repeat
// pixel raises dup_err and is not counted. Without it, dup_err is tied low and
// every accepted strobe is counted.
module pixel_framebuf #(
    parameter int DRAIN_BOTTOM_UP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       busy,
    input  logic       po,
    input  logic [2:0] xo,
    input  logic [2:0] yo,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [2:0] row_idx,
    output logic [7:0] row_data,
    output logic [6:0] pix_cnt,
    output logic       frame_done,
    output logic       overrun,
    output logic       dup_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [2:0] FIRST_ROW = (DRAIN_BOTTOM_UP != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_ROW  = (DRAIN_BOTTOM_UP != 0) ? 3'd0 : 3'd7;
    localparam logic [6:0] CNT_MAX   = 7'd127;

    // Extract one 8-pixel row; bit n of the result is column n.
    function automatic logic [7:0] row_of(input logic [63:0] bm, input logic [2:0] r);
        row_of = bm[{r, 3'b000} +: 8];
    endfunction

    // Row that follows r in the configured drain order.
    function automatic logic [2:0] row_after(input logic [2:0] r);
        if (DRAIN_BOTTOM_UP != 0) begin
            row_after = r - 3'd1;
        end else begin
            row_after = r + 3'd1;
        end
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [63:0] bitmap_r;
    logic [63:0] bitmap_s;
    logic [6:0]  pix_cnt_r;
    logic        row_valid_r;
    logic [2:0]  row_idx_r;
    logic [7:0]  row_data_r;
    logic        frame_done_r;
    logic        overrun_r;
    logic        dup_err_r;

    logic [5:0]  pix_idx_s;
    logic        capture_s;
    logic        inc_s;
    logic        dup_s;
    logic        handshake_s;
    logic        final_s;
    logic        enter_drain_s;
`ifdef DUP_DETECT_EN
    logic        hit_s;
`endif

    // Pixel bookkeeping and drain handshake decode.
    always_comb begin
        pix_idx_s     = {yo, xo};
        capture_s     = po && (state_r != DRAIN);
        handshake_s   = (state_r == DRAIN) && row_valid_r && row_ready;
        final_s       = handshake_s && (row_idx_r == LAST_ROW);
        enter_drain_s = (state_r == CAPTURE) && !busy;
`ifdef DUP_DETECT_EN
        hit_s         = bitmap_r[pix_idx_s];
        inc_s         = capture_s && !hit_s;
        dup_s         = capture_s && hit_s;
`else
        inc_s         = capture_s;
        dup_s         = 1'b0;
`endif
    end

    // FSM next state and next bitmap contents.
    always_comb begin
        state_s  = state_r;
        bitmap_s = bitmap_r;
        case (state_r)
            IDLE: begin
                if (busy) begin
                    state_s = CAPTURE;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (!busy) begin
                    state_s = DRAIN;
                end else begin
                    state_s = CAPTURE;
                end
            end
            DRAIN: begin
                if (final_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (capture_s) begin
            bitmap_s[pix_idx_s] = 1'b1;
        end else if (final_s) begin
            bitmap_s = 64'd0;
        end else begin
            bitmap_s = bitmap_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bitmap, pixel count, sticky error flags and frame-done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitmap_r     <= 64'd0;
            pix_cnt_r    <= 7'd0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            dup_err_r    <= 1'b0;
        end else begin
            bitmap_r     <= bitmap_s;
            frame_done_r <= final_s;
            overrun_r    <= overrun_r | (po && (state_r == DRAIN));
            dup_err_r    <= dup_err_r | dup_s;
            if (final_s) begin
                pix_cnt_r <= 7'd0;
            end else if (inc_s && (pix_cnt_r != CNT_MAX)) begin
                pix_cnt_r <= pix_cnt_r + 7'd1;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
        end
    end

    // Drain port registers. Row data is loaded from the next-state bitmap on DRAIN entry.
    // This way, a pixel on the busy-falling edge already appears in the first row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_valid_r <= 1'b0;
            row_idx_r   <= 3'd0;
            row_data_r  <= 8'd0;
        end else if (enter_drain_s) begin
            row_valid_r <= 1'b1;
            row_idx_r   <= FIRST_ROW;
            row_data_r  <= row_of(bitmap_s, FIRST_ROW);
        end else if (final_s) begin
            row_valid_r <= 1'b0;
            row_idx_r   <= 3'd0;
            row_data_r  <= 8'd0;
        end else if (handshake_s) begin
            row_valid_r <= 1'b1;
            row_idx_r   <= row_after(row_idx_r);
            row_data_r  <= row_of(bitmap_r, row_after(row_idx_r));
        end else begin
            row_valid_r <= row_valid_r;
            row_idx_r   <= row_idx_r;
            row_data_r  <= row_data_r;
        end
    end

    assign row_valid  = row_valid_r;
    assign row_idx    = row_idx_r;
    assign row_data   = row_data_r;
    assign pix_cnt    = pix_cnt_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;
    assign dup_err    = dup_err_r;

endmodule

// File: tb/tb_pixel_framebuf.sv
// Bench for pixel_framebuf. One top-down and one bottom-up instance share all inputs.
// A reference bitmap (one bit per pixel), a pixel count and the sticky flags
// predict every drained row and status output.
module tb_pixel_framebuf;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy = 1'b0;
    logic       po = 1'b0;
    logic [2:0] xo = 3'd0;
    logic [2:0] yo = 3'd0;
    logic       row_ready = 1'b0;

    logic       a_valid, b_valid;
    logic [2:0] a_idx, b_idx;
    logic [7:0] a_data, b_data;
    logic [6:0] a_cnt, b_cnt;
    logic       a_done, b_done, a_ov, b_ov, a_dup, b_dup;

    int n_tests = 0;
    int n_fail  = 0;

    bit bm[64];
    int cnt = 0;
    bit ov  = 1'b0;
    bit dup = 1'b0;

    pixel_framebuf #(.DRAIN_BOTTOM_UP(0)) dut_a (
        .clk(clk), .reset(reset), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .row_valid(a_valid), .row_ready(row_ready), .row_idx(a_idx), .row_data(a_data),
        .pix_cnt(a_cnt), .frame_done(a_done), .overrun(a_ov), .dup_err(a_dup)
    );

    pixel_framebuf #(.DRAIN_BOTTOM_UP(1)) dut_b (
        .clk(clk), .reset(reset), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .row_valid(b_valid), .row_ready(row_ready), .row_idx(b_idx), .row_data(b_data),
        .pix_cnt(b_cnt), .frame_done(b_done), .overrun(b_ov), .dup_err(b_dup)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_pix(input int p);
`ifdef DUP_DETECT_EN
        if (bm[p]) begin
            dup = 1'b1;
        end else begin
            bm[p] = 1'b1;
            if (cnt < 127) cnt++;
        end
`else
        bm[p] = 1'b1;
        if (cnt < 127) cnt++;
`endif
    endfunction

    function automatic logic [7:0] mrow(input int y);
        logic [7:0] v;
        for (int x = 0; x < 8; x++) v[x] = bm[y * 8 + x];
        return v;
    endfunction

    function automatic void model_clear_frame();
        for (int i = 0; i < 64; i++) bm[i] = 1'b0;
        cnt = 0;
    endfunction

    // Feed one pixel (y*8+x) per cycle while busy; -1 means no strobe that cycle.
    // The last entry lands on the busy-falling cycle.
    task automatic capture(input int pq[$]);
        if (pq.size() == 0) begin
            busy = 1'b1; po = 1'b0; step();
        end
        for (int i = 0; i < pq.size(); i++) begin
            busy = !((i == pq.size() - 1) && (pq.size() >= 2));
            po = (pq[i] >= 0);
            if (pq[i] >= 0) begin
                xo = 3'(pq[i] % 8);
                yo = 3'(pq[i] / 8);
                model_pix(pq[i]);
            end
            step();
        end
        if (pq.size() < 2) begin
            busy = 1'b0; po = 1'b0; step();
        end
        busy = 1'b0; po = 1'b0;
        n_tests++;
        if (a_cnt !== 7'(cnt) || b_cnt !== 7'(cnt)) begin
            n_fail++;
            $display("FAIL pix_cnt: got a=%0d b=%0d want %0d", a_cnt, b_cnt, cnt);
        end
        n_tests++;
        if (a_dup !== dup || b_dup !== dup || a_ov !== ov || b_ov !== ov) begin
            n_fail++;
            $display("FAIL flags: got dup=%b/%b ov=%b/%b want dup=%b ov=%b", a_dup, b_dup, a_ov, b_ov, dup, ov);
        end
    endtask

    // Drain n_hs rows. mode 0: no stalls, 1: random stalls, 2: 3-cycle stall on row srow.
    // ov_at: row index (loop count) during whose stall a (5,5) pixel arrives (-1: none).
    task automatic drain(input int mode, input int srow, input int ov_at, input int n_hs);
        for (int r = 0; r < n_hs; r++) begin
            int st;
            logic [2:0] ea, eb;
            ea = 3'(r);
            eb = 3'(7 - r);
            st = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2 && r == srow) ? 3 : 0);
            if (r == ov_at && st == 0) st = 1;
            for (int k = 0; k <= st; k++) begin
                n_tests++;
                if (a_valid !== 1'b1 || a_idx !== ea || a_data !== mrow(r)) begin
                    n_fail++;
                    $display("FAIL row_a: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", a_valid, a_idx, a_data, ea, mrow(r));
                end
                n_tests++;
                if (b_valid !== 1'b1 || b_idx !== eb || b_data !== mrow(7 - r)) begin
                    n_fail++;
                    $display("FAIL row_b: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", b_valid, b_idx, b_data, eb, mrow(7 - r));
                end
                if (k < st) begin
                    row_ready = 1'b0;
                    po = (r == ov_at && k == 0);
                    xo = 3'd5; yo = 3'd5;
                    if (po) ov = 1'b1;
                    busy = 1'($urandom_range(0, 1));
                end else begin
                    row_ready = 1'b1;
                    po = 1'b0;
                    busy = (r == 7) ? 1'b0 : 1'($urandom_range(0, 1));
                end
                step();
            end
            po = 1'b0;
        end
        row_ready = 1'b0;
        busy = 1'b0;
        if (n_hs == 8) begin
            n_tests++;
            if (a_done !== 1'b1 || b_done !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_end: got done=%b/%b valid=%b/%b want done=1 valid=0", a_done, b_done, a_valid, b_valid);
            end
            n_tests++;
            if (a_idx !== 3'd0 || a_data !== 8'd0 || b_idx !== 3'd0 || b_data !== 8'd0 || a_cnt !== 7'd0 || b_cnt !== 7'd0) begin
                n_fail++;
                $display("FAIL frame_clear: got idx=%0d/%0d data=%h/%h cnt=%0d/%0d want all 0", a_idx, b_idx, a_data, b_data, a_cnt, b_cnt);
            end
            n_tests++;
            if (a_ov !== ov || b_ov !== ov) begin
                n_fail++;
                $display("FAIL overrun: got %b/%b want %b", a_ov, b_ov, ov);
            end
            model_clear_frame();
            step();
            n_tests++;
            if (a_done !== 1'b0 || b_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse: got %b/%b want 0", a_done, b_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_tests++;
        if ({a_valid, a_idx, a_data, a_cnt, a_done, a_ov, a_dup} !== 23'd0 ||
            {b_valid, b_idx, b_data, b_cnt, b_done, b_ov, b_dup} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset: got a=%h b=%h want 0",
                     {a_valid, a_idx, a_data, a_cnt, a_done, a_ov, a_dup},
                     {b_valid, b_idx, b_data, b_cnt, b_done, b_ov, b_dup});
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int pq[$];
        pq = '{0, 1 * 8 + 2, 7 * 8 + 7};
        capture(pq);
        drain(0, 0, -1, 8);
    endtask

    task automatic test_stall();
        int pq[$];
        pq = '{0, 1 * 8 + 2, 7 * 8 + 7};
        capture(pq);
        drain(2, 1, -1, 8);
    endtask

    task automatic test_dup();
        int pq[$];
        pq = '{3 * 8 + 3, 3 * 8 + 3};
        capture(pq);
        n_tests++;
`ifdef DUP_DETECT_EN
        if (a_cnt !== 7'd1 || a_dup !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_detect: got cnt=%0d dup=%b want cnt=1 dup=1", a_cnt, a_dup);
        end
`else
        if (a_cnt !== 7'd2 || a_dup !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_count: got cnt=%0d dup=%b want cnt=2 dup=0", a_cnt, a_dup);
        end
`endif
        n_tests++;
        if (a_data !== 8'd0 || b_data !== 8'd0) begin
            n_fail++;
            $display("FAIL dup_first_rows: got %h/%h want 00/00", a_data, b_data);
        end
        drain(1, 0, -1, 8);
    endtask

    task automatic test_overrun();
        int pq[$];
        pq = '{0, 1 * 8 + 2, 7 * 8 + 7};
        capture(pq);
        drain(0, 0, 2, 8);
        pq = '{4 * 8 + 4, -1, 6 * 8 + 1};
        capture(pq);
        drain(1, 0, -1, 8);
    endtask

    task automatic test_empty();
        int pq[$];
        pq = {};
        capture(pq);
        drain(1, 0, -1, 8);
    endtask

    task automatic test_reset_drain();
        int pq[$];
        pq = '{2 * 8 + 2, 5 * 8 + 6, 7 * 8 + 0};
        capture(pq);
        drain(1, 0, -1, 4);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({a_valid, a_idx, a_data, a_cnt, a_done, a_ov, a_dup} !== 23'd0 ||
            {b_valid, b_idx, b_data, b_cnt, b_done, b_ov, b_dup} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got a=%h b=%h want 0",
                     {a_valid, a_idx, a_data, a_cnt, a_done, a_ov, a_dup},
                     {b_valid, b_idx, b_data, b_cnt, b_done, b_ov, b_dup});
        end
        model_clear_frame();
        ov = 1'b0;
        dup = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (a_done !== 1'b0 || b_done !== 1'b0 || a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL no_done_after_reset: got done=%b/%b valid=%b want 0", a_done, b_done, a_valid);
            end
        end
        pq = '{1 * 8 + 3};
        capture(pq);
        drain(0, 0, -1, 8);
    endtask

    task automatic test_bottom_up();
        int pq[$];
        pq = '{6 * 8 + 1};
        capture(pq);
        n_tests++;
        if (b_idx !== 3'd7 || b_data !== 8'h00) begin
            n_fail++;
            $display("FAIL bottom_up_first: got idx=%0d data=%h want idx=7 data=00", b_idx, b_data);
        end
        drain(0, 0, -1, 8);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 20; f++) begin
            int pq[$];
            int n;
            n = $urandom_range(0, 20);
            pq = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) pq.push_back(-1);
                else pq.push_back(int'($urandom_range(0, 63)));
            end
            capture(pq);
            drain(1, 0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 8);
        end
    endtask

    task automatic test_saturate();
        int pq[$];
        pq = {};
        for (int i = 0; i < 130; i++) pq.push_back(int'($urandom_range(0, 63)));
        capture(pq);
        drain(1, 0, -1, 8);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bm[i] = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_dup();
        test_overrun();
        test_empty();
        test_reset_drain();
        test_bottom_up();
        test_random_frames();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
